// File: rtl/sevenseg_scan_capture.sv
// Rebuilds the frame shown on a multiplexed 4-digit 7-segment bus
// and decodes each captured digit pattern to a character code.
module sevenseg_scan_capture #(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  AN,
   input  logic [6:0]  DISP,
   output logic [27:0] FRAME,
   output logic [19:0] CODES,
   output logic        FRAME_VALID,
   output logic        ERR_MULTI,
   output logic        SCAN_TIMEOUT
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);
   localparam logic [7:0] STB_AT = 8'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

   logic [10:0]     samp_q, samp_d;
   logic [7:0]      stab_q, stab_d;
   logic [3:0]      seen_q, seen_d;
   logic [3:0][6:0] shad_q, shad_d;
   logic [27:0]     frame_q, frame_d;
   logic [19:0]     codes_q, codes_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic            fv_q, err_q, err_d, to_q, to_d;
   logic [3:0]      an_n;
   logic            stb, one_low, multi, cap, done, tmo_hit;

   function automatic logic [4:0] dec(input logic [6:0] p);
      unique case (p)
         7'b1000000: dec = 5'h00;
         7'b1111001: dec = 5'h01;
         7'b0100100: dec = 5'h02;
         7'b0110000: dec = 5'h03;
         7'b0011001: dec = 5'h04;
         7'b0010010: dec = 5'h05;
         7'b0000010: dec = 5'h06;
         7'b1111000: dec = 5'h07;
         7'b0000000: dec = 5'h08;
         7'b0010000: dec = 5'h09;
         7'b0001000: dec = 5'h0A;
         7'b0000011: dec = 5'h0B;
         7'b1000110: dec = 5'h0C;
         7'b0100001: dec = 5'h0D;
         7'b0000110: dec = 5'h0E;
         7'b0001110: dec = 5'h0F;
         7'b1111111: dec = 5'h10;
         7'b0111111: dec = 5'h11;
         default:    dec = 5'h1F;
      endcase
   endfunction

   always_comb begin
      samp_d = {AN, DISP};
      if (samp_d != samp_q)
         stab_d = '0;
      else if (stab_q == SETTLE)
         stab_d = stab_q;
      else
         stab_d = stab_q + 8'd1;

      // counter passes STB_AT exactly once per stable episode
      stb     = (stab_q == STB_AT);
      an_n    = ~samp_q[10:7];
      one_low = (an_n != '0) && ((an_n & (an_n - 4'd1)) == '0);
      multi   = (an_n != '0) && !one_low;
      cap     = stb && one_low;
      err_d   = stb && multi;

      shad_d = shad_q;
      for (int i = 0; i < 4; i++)
         if (cap && an_n[i]) shad_d[i] = samp_q[6:0];

      done = cap && ((seen_q | an_n) == 4'hF);

      if (done)
         tmo_d = '0;
      else if (tmo_q == TMO)
         tmo_d = tmo_q;
      else
         tmo_d = tmo_q + 1'b1;
      tmo_hit = (tmo_d == TMO) && (tmo_q != TMO);

      if (done || tmo_hit)
         seen_d = '0;
      else if (cap)
         seen_d = seen_q | an_n;
      else
         seen_d = seen_q;

      if (done)
         to_d = 1'b0;
      else if (tmo_hit)
         to_d = 1'b1;
      else
         to_d = to_q;

      frame_d = done ? shad_d : frame_q;
      codes_d = done ? {dec(frame_d[27:21]), dec(frame_d[20:14]),
                        dec(frame_d[13:7]), dec(frame_d[6:0])}
                     : codes_q;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         samp_q  <= '1;
         stab_q  <= '0;
         seen_q  <= '0;
         shad_q  <= '1;
         frame_q <= '1;
         codes_q <= {4{5'h10}};
         tmo_q   <= '0;
         fv_q    <= 1'b0;
         err_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         samp_q  <= samp_d;
         stab_q  <= stab_d;
         seen_q  <= seen_d;
         shad_q  <= shad_d;
         frame_q <= frame_d;
         codes_q <= codes_d;
         tmo_q   <= tmo_d;
         fv_q    <= done;
         err_q   <= err_d;
         to_q    <= to_d;
      end
   end

   assign FRAME        = frame_q;
   assign CODES        = codes_q;
   assign FRAME_VALID  = fv_q;
   assign ERR_MULTI    = err_q;
   assign SCAN_TIMEOUT = to_q;

endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Directed bench for sevenseg_scan_capture; expected frames are queued
// as each scan is driven and compared when FRAME_VALID pulses.
module tb_sevenseg_scan_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  an;
   logic [6:0]  disp;
   logic [27:0] frame;
   logic [19:0] codes;
   logic        fv, em, to;

   always #5 clk = ~clk;

   sevenseg_scan_capture #(
      .SETTLE_CYCLES (16),
      .TIMEOUT_CYCLES(1000)
   ) dut (
      .CLK         (clk),
      .RST         (rst),
      .AN          (an),
      .DISP        (disp),
      .FRAME       (frame),
      .CODES       (codes),
      .FRAME_VALID (fv),
      .ERR_MULTI   (em),
      .SCAN_TIMEOUT(to)
   );

   typedef struct {
      logic [27:0] f;
      logic [19:0] c;
   } exp_t;

   exp_t q[$];
   int checks = 0, failures = 0;
   int fv_cnt = 0, err_cnt = 0, cyc_n = 0;
   int fv_at = -1, to_rise_at = -1, to_fall_at = -1;
   int k, e0, f0;
   logic to_prev = 1'b0;

   localparam logic [6:0] D0 = 7'b1000000, D1 = 7'b1111001;
   localparam logic [6:0] D2 = 7'b0100100, D3 = 7'b0110000;
   localparam logic [6:0] D4 = 7'b0011001, D5 = 7'b0010010;
   localparam logic [6:0] D6 = 7'b0000010, D7 = 7'b1111000;
   localparam logic [6:0] D8 = 7'b0000000, D9 = 7'b0010000;
   localparam logic [6:0] DA = 7'b0001000, DB = 7'b0000011;
   localparam logic [6:0] DC = 7'b1000110, DE = 7'b0000110;
   localparam logic [6:0] DF = 7'b0001110, DASH = 7'b0111111;
   localparam logic [6:0] UNK = 7'b1010101, BLK = 7'b1111111;

   function automatic logic [4:0] tdec(input logic [6:0] p);
      case (p)
         D0: return 5'h00;
         D1: return 5'h01;
         D2: return 5'h02;
         D3: return 5'h03;
         D4: return 5'h04;
         D5: return 5'h05;
         D6: return 5'h06;
         D7: return 5'h07;
         D8: return 5'h08;
         D9: return 5'h09;
         DA: return 5'h0A;
         DB: return 5'h0B;
         DC: return 5'h0C;
         7'b0100001: return 5'h0D;
         DE: return 5'h0E;
         DF: return 5'h0F;
         BLK: return 5'h10;
         DASH: return 5'h11;
         default: return 5'h1F;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [47:0] obs,
                      input logic [47:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [6:0] d3, d2, d1, d0);
      exp_t e;
      e.f = {d3, d2, d1, d0};
      e.c = {tdec(d3), tdec(d2), tdec(d1), tdec(d0)};
      q.push_back(e);
   endtask

   task automatic cyc();
      exp_t e;
      @(negedge clk);
      cyc_n++;
      if (fv === 1'b1) begin
         fv_cnt++;
         fv_at = cyc_n;
         checks++;
         assert (q.size() > 0) else begin
            failures++;
            $error("FAIL fv_expected observed=pulse expected=none cyc=%0d",
                   cyc_n);
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("frame", 48'(frame), 48'(e.f));
            chk("codes", 48'(codes), 48'(e.c));
         end
      end
      if (em === 1'b1) err_cnt++;
      if (to === 1'b1 && to_prev !== 1'b1) to_rise_at = cyc_n;
      if (to !== 1'b1 && to_prev === 1'b1) to_fall_at = cyc_n;
      to_prev = to;
   endtask

   task automatic hold(input logic [3:0] a, input logic [6:0] d,
                       input int n);
      an   = a;
      disp = d;
      repeat (n) cyc();
   endtask

   initial begin
      // reset with random pins
      rst  = 1'b1;
      an   = 4'($urandom);
      disp = 7'($urandom);
      cyc();
      an   = 4'($urandom);
      disp = 7'($urandom);
      cyc();
      chk("rst_frame", 48'(frame), 48'h0FFFFFFF);
      chk("rst_codes", 48'(codes), 48'h84210);
      chk("rst_fv", 48'(fv), 48'd0);
      chk("rst_err", 48'(em), 48'd0);
      chk("rst_to", 48'(to), 48'd0);
      rst = 1'b0;
      hold(4'hF, BLK, 10);

      // normal scan with latency check
      k = fv_cnt;
      hold(4'b0111, D0, 100);
      hold(4'b1011, D1, 100);
      hold(4'b1101, D2, 100);
      push(D0, D1, D2, D3);
      hold(4'b1110, D3, 16);
      chk("lat_16", 48'(fv), 48'd0);
      hold(4'b1110, D3, 1);
      chk("lat_17", 48'(fv), 48'd1);
      hold(4'b1110, D3, 83);
      chk("normal_fv", 48'(fv_cnt - k), 48'd1);

      // short glitch must not be captured
      k = fv_cnt;
      hold(4'b0111, D5, 100);
      hold(4'b1110, D8, 10);
      hold(4'b1011, D6, 100);
      hold(4'b1101, D7, 100);
      chk("glitch10_nofv", 48'(fv_cnt - k), 48'd0);
      push(D5, D6, D7, DA);
      hold(4'b1110, DA, 100);
      chk("glitch10_fv", 48'(fv_cnt - k), 48'd1);

      // 16-cycle glitch is a real capture
      k = fv_cnt;
      hold(4'b0111, DB, 100);
      hold(4'b1110, D8, 16);
      hold(4'b1011, DC, 100);
      push(DB, DC, DASH, D8);
      hold(4'b1101, DASH, 100);
      chk("glitch16_fv", 48'(fv_cnt - k), 48'd1);
      hold(4'hF, BLK, 20);

      // multiple anodes low
      k  = fv_cnt;
      e0 = err_cnt;
      hold(4'b0011, D1, 50);
      chk("multi_err", 48'(err_cnt - e0), 48'd1);
      hold(4'b1110, DE, 100);
      hold(4'b1101, DF, 100);
      chk("multi_nofv", 48'(fv_cnt - k), 48'd0);
      hold(4'b0111, D9, 100);
      push(D9, D4, DF, DE);
      hold(4'b1011, D4, 100);
      chk("multi_fv", 48'(fv_cnt - k), 48'd1);
      chk("multi_err_total", 48'(err_cnt - e0), 48'd1);

      // timeout
      k = fv_cnt;
      hold(4'b0111, D1, 100);
      hold(4'b1011, D2, 100);
      hold(4'b1101, D3, 100);
      push(D1, D2, D3, D4);
      hold(4'b1110, D4, 100);
      chk("to_pre_fv", 48'(fv_cnt - k), 48'd1);
      f0 = fv_at;
      hold(4'b0111, D7, 100);
      hold(4'b1011, D7, 100);
      hold(4'hF, BLK, 850);
      chk("to_rise_delay", 48'(to_rise_at - f0), 48'd1000);
      hold(4'hF, BLK, 100);
      chk("to_held", 48'(to), 48'd1);
      hold(4'b1101, D5, 100);
      hold(4'b1110, D6, 100);
      chk("to_seen_cleared", 48'(fv_cnt - k), 48'd1);
      push(D8, D9, D5, D6);
      hold(4'b0111, D8, 100);
      hold(4'b1011, D9, 100);
      chk("to_resume_fv", 48'(fv_cnt - k), 48'd2);
      chk("to_fall_with_fv", 48'(to_fall_at), 48'(fv_at));
      chk("to_low", 48'(to), 48'd0);

      // reset mid-frame drops partial captures
      k = fv_cnt;
      hold(4'b0111, D3, 100);
      hold(4'b1011, D2, 100);
      rst = 1'b1;
      hold(4'hF, BLK, 2);
      rst = 1'b0;
      chk("rst_mid_frame", 48'(frame), 48'h0FFFFFFF);
      chk("rst_mid_codes", 48'(codes), 48'h84210);
      hold(4'b1101, D1, 100);
      hold(4'b1110, UNK, 100);
      chk("rst_mid_nofv", 48'(fv_cnt - k), 48'd0);
      push(DA, DC, D1, UNK);
      hold(4'b0111, DA, 100);
      hold(4'b1011, DC, 100);
      chk("rst_mid_fv", 48'(fv_cnt - k), 48'd1);
      chk("unk_code", 48'(codes[4:0]), 48'h1F);
      hold(4'hF, BLK, 20);

      chk("fv_total", 48'(fv_cnt), 48'd7);
      chk("queue_empty", 48'(q.size()), 48'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sevenseg_scan_capture.md
Name: sevenseg_scan_capture

Overview:
- Monitors a time-multiplexed 4-digit 7-segment bus (active-low anodes AN, active-low segments DISP in GFEDCBA order).
- Reconstructs the 28-bit frame currently being shown and decodes each digit to a character code.
- Sits at the panel end of the display interface, for board loopback self-check and for scoreboarding the marquee/display drivers in simulation.

Parameters:
- SETTLE_CYCLES, 16: consecutive identical samples required before a digit is captured (range 2..255).
- TIMEOUT_CYCLES, 2000000: cycles without a completed frame before SCAN_TIMEOUT asserts (default = 2 full scans at 250000 cycles/digit).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- AN  in  4  anode enables, active-low; AN[3] = leftmost digit.
- DISP  in  7  segments, active-low, bit6 = G .. bit0 = A.
- FRAME  out  28  {digit3,digit2,digit1,digit0} raw segment patterns of the last complete frame.
- CODES  out  20  {code3,code2,code1,code0}, 5 bits each, decoded from FRAME.
- FRAME_VALID  out  1  one-cycle pulse when FRAME/CODES update.
- ERR_MULTI  out  1  one-cycle pulse: a stable sample had more than one anode low.
- SCAN_TIMEOUT  out  1  level: no frame completed within TIMEOUT_CYCLES.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - FRAME=28'hFFFFFFF; CODES all 5'h10.
  - FRAME_VALID=0, ERR_MULTI=0, SCAN_TIMEOUT=0.
  - seen mask=4'b0000, stability and timeout counters=0, sample register=all ones.
  - Reset asserted mid-frame discards all partial captures.
- Sampling: {AN,DISP} is registered every cycle (1-cycle input latency).
- Stability counter:
  - Cleared when the new sample differs from the previous sample; otherwise increments, saturating at SETTLE_CYCLES.
  - A capture strobe fires on the single cycle the counter reaches SETTLE_CYCLES-1 (the same value sampled SETTLE_CYCLES times in a row).
  - Exactly one strobe per stable episode; a held value never re-fires.
- Anode classification at the strobe:
  - Exactly one AN bit low: capture DISP into shadow[idx], set seen[idx].
  - AN=4'b1111: blanking interval, ignored.
  - Two or more AN bits low: ERR_MULTI pulses the next cycle; no capture; seen unchanged.
- Frame assembly is order-independent. Recapturing an index already in seen overwrites its shadow entry without error.
- Frame completion: when a capture makes seen=4'b1111, on the next cycle:
  - FRAME is loaded with the shadow contents, including the digit just captured.
  - CODES are updated combinationally from the new FRAME, registered in the same cycle.
  - FRAME_VALID=1 for one cycle; seen cleared; timeout counter cleared; SCAN_TIMEOUT deasserts.
- Latency: FRAME_VALID is high 1 cycle after the completing strobe, i.e. SETTLE_CYCLES+1 cycles after the final digit value first appears on the pins.
- Timeout:
  - Counter increments every cycle and saturates.
  - On reaching TIMEOUT_CYCLES, SCAN_TIMEOUT=1 (held) and seen is cleared once.
  - SCAN_TIMEOUT clears only with the next FRAME_VALID or reset.
- Code table (DISP pattern -> code):
  - 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7.
  - 0000000->8, 0010000->9, 0001000->A, 0000011->B, 1000110->C, 0100001->D, 0000110->E, 0001110->F.
  - 1111111->5'h10 (blank), 0111111->5'h11 (dash), anything else->5'h1F.
- Simultaneous events:
  - Completing capture and timeout terminal count in the same cycle: frame completion wins; SCAN_TIMEOUT stays 0.
  - ERR_MULTI never coincides with a capture.

Test Plan:
- Reset: RST=1 for 2 cycles with random AN/DISP -> FRAME=28'hFFFFFFF, CODES=20'h84210 (all 5'h10), all flags 0.
- Normal scan (SETTLE_CYCLES=16): hold AN=0111/DISP=1000000, AN=1011/1111001, AN=1101/0100100, AN=1110/0110000, 100 cycles each -> single FRAME_VALID 17 cycles after the last digit is applied, FRAME={1000000,1111001,0100100,0110000}, CODES={0,1,2,3}.
- Glitch rejection: insert AN=1110/DISP=0000000 for 10 cycles between digits -> no capture, seen unchanged; next FRAME unaffected. Repeat with 16 cycles -> captured.
- Multi-anode: hold AN=0011 for 50 cycles -> exactly one ERR_MULTI pulse, no FRAME_VALID, seen unchanged.
- Timeout (TIMEOUT_CYCLES=1000): complete one frame, then hold AN=1111 -> SCAN_TIMEOUT rises 1000 cycles after FRAME_VALID and stays high. Resume a full scan -> SCAN_TIMEOUT falls on the same cycle FRAME_VALID pulses.
- Reset mid-frame: capture digits 3 and 2, pulse RST, then capture 1 and 0 only -> no FRAME_VALID until digits 3 and 2 are recaptured. Also check unknown pattern 1010101 decodes to 5'h1F.
